// File: rtl/divider_seq_pkg.sv
// Shared types and default widths for the divider sequencer.
package divider_seq_pkg;

    // Sequencer states; busy is simply "not IDLE".
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b11,
        DONE = 2'b10
    } seq_state_t;

    localparam int DEF_N_ENTRIES = 4;
    localparam int DEF_DIV_W     = 8;
    localparam int DEF_REP_W     = 4;

endpackage

// File: rtl/divider_sequencer_period_counter.sv
// Free-running period counter: counts 0..div-1 while enabled and flags the
// last count of each period as terminal.
module period_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             terminal
);

    logic [DIV_W-1:0] cnt;

    // div is never 0 while enabled, so div-1 cannot underflow in use and
    // cnt never exceeds div-1 (no overflow).
    assign terminal = en && (cnt == div - DIV_W'(1));

    // Count up while enabled, wrap to 0 on terminal, hold 0 when cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= terminal ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/divider_sequencer.sv
// Table-driven pulse sequencer: walks N_ENTRIES {div, rep} entries, emitting
// rep one-cycle pulses spaced div cycles apart for each non-empty entry.
module divider_sequencer
    import divider_seq_pkg::*;
#(
    parameter int N_ENTRIES = DEF_N_ENTRIES,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int REP_W     = DEF_REP_W,
    localparam int IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic             start,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             cfg_rejected
);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [REP_W-1:0] rep_left_q;
    logic [DIV_W-1:0] tbl_div [N_ENTRIES];
    logic [REP_W-1:0] tbl_rep [N_ENTRIES];

    logic [DIV_W-1:0] cur_div;
    logic [REP_W-1:0] cur_rep;
    logic             entry_skip;
    logic             is_last;
    logic             term;
    logic             run_en;

    assign cur_div    = tbl_div[idx_q];
    assign cur_rep    = tbl_rep[idx_q];
    assign entry_skip = (cur_div == '0) || (cur_rep == '0);
    assign is_last    = (idx_q == IDX_W'(N_ENTRIES - 1));
    assign busy       = (state_q != IDLE);
    // Gating with abort keeps a terminal on the abort cycle from producing out.
    assign run_en     = (state_q == RUN) && !abort;

    period_counter #(.DIV_W(DIV_W)) u_period (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!run_en),
        .en       (run_en),
        .div      (cur_div),
        .terminal (term)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides everything once the block is busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !abort) state_d = LOAD;
            LOAD: begin
                if (!entry_skip)  state_d = RUN;
                else if (is_last) state_d = DONE;
                else              state_d = LOAD;
            end
            RUN: begin
                if (term && rep_left_q == REP_W'(1))
                    state_d = is_last ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // Entry index, remaining repeats and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            rep_left_q   <= '0;
            out          <= 1'b0;
            done         <= 1'b0;
            cfg_rejected <= 1'b0;
        end else begin
            out          <= term;
            done         <= (state_d == DONE);
            cfg_rejected <= cfg_we && busy;
            if (!abort) begin
                case (state_q)
                    IDLE: if (start) idx_q <= '0;
                    LOAD: begin
                        if (entry_skip) idx_q      <= idx_q + IDX_W'(1);
                        else            rep_left_q <= cur_rep;
                    end
                    RUN: begin
                        if (term) begin
                            rep_left_q <= rep_left_q - REP_W'(1);
                            if (rep_left_q == REP_W'(1)) idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sequence table: writable only while idle, cleared to empty on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                tbl_div[i] <= '0;
                tbl_rep[i] <= '0;
            end
        end else if (cfg_we && state_q == IDLE) begin
            tbl_div[cfg_addr] <= cfg_div;
            tbl_rep[cfg_addr] <= cfg_rep;
        end
    end

endmodule
